// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared CFU types, function IDs and arithmetic helpers for the dot-product unit
package dotprod_pkg;
  typedef enum logic [1:0] {CFU_OK, CFU_ERROR_FUNC, CFU_ERROR_STATE, CFU_ERROR_OFF} cfu_status_t;
  typedef enum logic [1:0] {CFU_CS_OFF, CFU_CS_INIT, CFU_CS_CLEAN, CFU_CS_DIRTY} cfu_cs_t;
  typedef struct packed {
    cfu_cs_t     cs;
    logic [19:0] rsvd;
    logic [9:0]  state_size;
  } cfu_csw_t;
  typedef enum logic [9:0] {DP = 10'd0, DP_ACC = 10'd1, SDP = 10'd2, SDP_ACC = 10'd3} dotprod_cfid_t;
  typedef enum logic [1:0] {IDLE, MAC, RESP} dotprod_fsm_t;
  localparam int F_WR_STATE = 1020;
  localparam int F_RD_STATE = 1021;
  localparam int F_WR_STATUS = 1022;
  localparam int F_RD_STATUS = 1023;

  function automatic int steps(input int data_w, input int elem_w, input int lanes);
    return data_w / elem_w / lanes;
  endfunction

  // Operands arrive already extended to 64 bits; w is the true result width.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w,
                                          input logic sgn, input logic sat);
    logic signed [65:0] s, hi, lo;
    s = (sgn ? {{2{a[63]}}, a} : {2'b0, a}) + (sgn ? {{2{b[63]}}, b} : {2'b0, b});
    hi = sgn ? (66'sd1 <<< (w - 1)) - 66'sd1 : (66'sd1 <<< w) - 66'sd1;
    lo = sgn ? -(66'sd1 <<< (w - 1)) : 66'sd0;
    return !sat ? s[63:0] : s > hi ? hi[63:0] : s < lo ? lo[63:0] : s[63:0];
  endfunction
endpackage

// File: rtl/dotprod_lane_mac.sv
// dotprod_lane_mac: LANES parallel element products summed into one W-bit partial
module dotprod_lane_mac #(
  parameter int W = 32,
  parameter int E = 8,
  parameter int LANES = 2
) (
  input  logic [LANES*E-1:0] a,
  input  logic [LANES*E-1:0] b,
  input  logic               sgn,
  output logic [W-1:0]       sum
);
  function automatic logic [W-1:0] ext(input logic [E-1:0] x, input logic s);
    return s ? W'(signed'(x)) : W'(x);
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + W'(ext(a[i*E+:E], sgn) * ext(b[i*E+:E], sgn));
  end
endmodule

// File: rtl/dotprod_l2_cxu.sv
// dotprod_l2_cxu: multi-context variable-latency dot-product CFU with req/resp handshake
module dotprod_l2_cxu
  import dotprod_pkg::*;
#(
  parameter int CFU_N_STATES   = 4,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_DATA_W     = 32,
  parameter int ELEM_W         = 8,
  parameter int LANES          = 2,
  parameter int SAT            = 0,
  parameter int CFU_STATE_ID_W = $clog2(CFU_N_STATES) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output cfu_status_t               resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data
);
  localparam int W = CFU_DATA_W;
  localparam int FW = CFU_FUNC_ID_W;
  localparam int STEPS = steps(CFU_DATA_W, ELEM_W, LANES);
  localparam int SLICE = LANES * ELEM_W;
  localparam int SW = $clog2(STEPS + 1);
  localparam int IW = CFU_N_STATES > 1 ? $clog2(CFU_N_STATES) : 1;
  localparam logic [FW-1:0] F_WST = FW'(F_WR_STATE);
  localparam logic [FW-1:0] F_RST = FW'(F_RD_STATE);
  localparam logic [FW-1:0] F_WSS = FW'(F_WR_STATUS);
  localparam logic [FW-1:0] F_RSS = FW'(F_RD_STATUS);
  localparam logic [FW-1:0] F_MAC_MAX = FW'(SDP_ACC);

  dotprod_fsm_t              fsm;
  logic [SW-1:0]             step;
  logic [W-1:0]              psum, op0, op1, sh0, sh1, lane_sum, dot, macc, racc, fin, nres;
  logic [63:0]               sa;
  logic [CFU_STATE_ID_W-1:0] st;
  logic [FW-1:0]             func;
  logic [IW-1:0]             idx, ridx;
  cfu_cs_t                   css [CFU_N_STATES];
  logic [CFU_N_STATES-1:0]   zaccs;
  logic [W-1:0]              accs [CFU_N_STATES];
  cfu_cs_t                   rcs;
  cfu_csw_t                  csw;
  cfu_status_t               nstat;
  logic                      rs_ok, is_stat, known, hs_resp, wr_acc, wr_status;

  function automatic logic [63:0] ext(input logic [W-1:0] x, input logic s);
    return s ? 64'(signed'(x)) : 64'(x);
  endfunction

  assign req_ready = clk_en && fsm == IDLE;
  assign sh0 = op0 >> (32'(step) * SLICE);
  assign sh1 = op1 >> (32'(step) * SLICE);

  dotprod_lane_mac #(.W(W), .E(ELEM_W), .LANES(LANES)) u_lane_mac (
    .a  (sh0[SLICE-1:0]),
    .b  (sh1[SLICE-1:0]),
    .sgn(func[1]),
    .sum(lane_sum)
  );

  always_comb begin
    rs_ok = 32'(req_state) < CFU_N_STATES;
    ridx = IW'(req_state);
    rcs = rs_ok ? css[ridx] : CFU_CS_OFF;
    is_stat = req_func == F_WSS || req_func == F_RSS;
    known = req_func <= F_MAC_MAX || req_func >= F_WST;
    nstat = !rs_ok ? CFU_ERROR_STATE : (rcs == CFU_CS_OFF && !is_stat) ? CFU_ERROR_OFF :
            !known ? CFU_ERROR_FUNC : CFU_OK;
    racc = zaccs[ridx] ? '0 : accs[ridx];
    csw = '{cs: rcs, rsvd: '0, state_size: 10'd1};
    nres = nstat != CFU_OK ? '0 : req_func == F_RST ? racc : req_func == F_WST ? req_data0 :
           req_func == F_RSS ? W'(csw) : '0;
    idx = IW'(st);
    macc = zaccs[idx] ? '0 : accs[idx];
    dot = psum + lane_sum;
    sa = sat_add(ext(macc, func[1]), ext(dot, func[1]), W, func[1], SAT != 0);
    fin = func[0] ? sa[W-1:0] : dot;
    hs_resp = clk_en && fsm == RESP && resp_ready;
    wr_acc = hs_resp && resp_status == CFU_OK && (func <= F_MAC_MAX || func == F_WST);
    wr_status = hs_resp && resp_status == CFU_OK && func == F_WSS;
  end

  always_ff @(posedge clk) if (wr_acc) accs[idx] <= resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      step <= '0;
      psum <= '0;
      st <= '0;
      func <= '0;
      op0 <= '0;
      op1 <= '0;
      resp_valid <= 1'b0;
      resp_status <= CFU_OK;
      resp_data <= '0;
      zaccs <= '1;
      for (int i = 0; i < CFU_N_STATES; i++) css[i] <= CFU_CS_INIT;
    end else if (clk_en) begin
      case (fsm)
        IDLE: if (req_valid) begin
          st <= req_state;
          func <= req_func;
          op0 <= req_data0;
          op1 <= req_data1;
          step <= '0;
          psum <= '0;
          if (nstat == CFU_OK && req_func <= F_MAC_MAX) fsm <= MAC;
          else begin
            fsm <= RESP;
            resp_valid <= 1'b1;
            resp_status <= nstat;
            resp_data <= nres;
          end
        end
        MAC: begin
          psum <= dot;
          step <= step + 1'b1;
          if (32'(step) == STEPS - 1) begin
            fsm <= RESP;
            resp_valid <= 1'b1;
            resp_status <= CFU_OK;
            resp_data <= fin;
          end
        end
        RESP: if (resp_ready) begin
          fsm <= IDLE;
          resp_valid <= 1'b0;
          // OFF and INIT both mean the context restarts from a zero accumulator
          if (wr_status) begin
            css[idx] <= cfu_cs_t'(op0[1:0]);
            if (op0[1:0] <= 2'(CFU_CS_INIT)) zaccs[idx] <= 1'b1;
          end else if (wr_acc) begin
            css[idx] <= CFU_CS_DIRTY;
            zaccs[idx] <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
